phv_ingress_sched: RTL
======================

Name: phv_ingress_sched

Overview:
- Schedules PHVs from several upstream parser ports into the first match-action stage, using round-robin arbitration.
- Counts PHVs in flight through the stage chain.
- Quiesces the data pipeline on request before stage reconfiguration, so control-path table/key writes never race live PHVs.
- Sits between the parsers and stage 0; also handshakes with the control-path packet filter.

Parameters:
- PHV_LEN, 1024: PHV width in bits (48*8+32*8+16*8+256).
- N_PORTS, 4: number of upstream PHV requesters (2..8).
- CNT_W, 8: width of the in-flight counter.
- MAX_INFLIGHT, 32: in-flight ceiling; must be < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_phv_in  in  N_PORTS*PHV_LEN  PHV from each port; port i occupies bits [i*PHV_LEN +: PHV_LEN]
- s_phv_valid  in  N_PORTS  per-port PHV valid
- s_ready_out  out  N_PORTS  per-port accept; one-hot or zero
- phv_out  out  PHV_LEN  PHV to stage 0
- phv_out_valid  out  1  PHV valid to stage 0
- stage_ready_in  in  1  stage 0 ready
- phv_done_valid  in  1  one-cycle pulse when a PHV leaves the last stage
- cfg_req  in  1  level; control packet waiting to reconfigure stages
- cfg_grant  out  1  level; pipeline quiescent, control packet may flow
- cfg_done  in  1  one-cycle pulse; last beat of control packet accepted
- inflight_cnt  out  CNT_W  PHVs issued and not yet done
- err_underflow  out  1  sticky; phv_done_valid seen with count 0

Behaviour:
- Reset values: all outputs 0; FSM=RUN; RR pointer=0; output register empty.
- Output register:
  - Single entry.
  - Issue = phv_out_valid & stage_ready_in.
  - phv_out and phv_out_valid stay stable until issue.
- can_load = (state==RUN) & (!phv_out_valid | stage_ready_in) & (inflight_cnt + phv_out_valid < MAX_INFLIGHT).
- Arbitration:
  - Winner = first valid port at or after RR pointer, scanning modulo N_PORTS.
  - When can_load, s_ready_out[winner]=1, all other bits 0. s_ready_out is combinational from valids, pointer, can_load.
  - On accept: register the winner's PHV, set phv_out_valid next cycle, and set pointer = (winner+1) mod N_PORTS (wraps N_PORTS-1 -> 0).
  - Pointer is unchanged when nothing is accepted.
  - Latency: accept at cycle t gives phv_out_valid at t+1.
  - Back-to-back accept every cycle while stage_ready_in=1.
- In-flight counter:
  - Issue only: +1. phv_done_valid only: -1. Both in the same cycle: unchanged.
  - phv_done_valid at 0: counter stays 0, err_underflow set until rst.
- FSM:
  - RUN: cfg_req=1 -> DRAIN; no new accepts from the following cycle.
  - DRAIN: !phv_out_valid & inflight_cnt==0 -> CFG. Pending output-register PHV still issues normally.
  - CFG: cfg_grant=1 (registered, asserted on entry cycle +1). cfg_done -> RUN, cfg_grant drops the next cycle.
  - cfg_req deasserting in DRAIN without cfg_done: stay in DRAIN until quiescent, enter CFG, wait for cfg_done. The request is not withdrawable.
  - cfg_done outside CFG: ignored.
- Async rst mid-operation: output register cleared (the PHV is dropped), counter 0, FSM RUN, cfg_grant 0.

Test Plan:
- Round-robin: all 4 ports valid continuously, stage_ready_in=1, rst released -> accept order 0,1,2,3,0,...; phv_out_valid high every cycle from cycle 1; one accept per cycle.
- Backpressure: stage_ready_in=0 for 5 cycles with port 2 loaded -> phv_out holds port-2 data, no s_ready_out, pointer stays 3; on ready=1 issue occurs and next accept is port 3.
- Counter: 10 issues, then phv_done_valid coincident with the 11th issue -> inflight_cnt=10; 10 further done pulses -> 0; one extra pulse -> err_underflow=1, cnt=0.
- Ceiling: MAX_INFLIGHT=4, no done pulses -> exactly 4 issues, s_ready_out=0 afterwards; a single done pulse admits exactly one more.
- Quiesce: inflight 3, cfg_req at t -> no accepts after t; 3 done pulses -> CFG, cfg_grant=1 one cycle later; cfg_done -> grant 0, accepts resume round-robin from the saved pointer.
- Reset mid-DRAIN: assert rst with cnt=5 and output valid -> all outputs 0 immediately, FSM RUN after release.

Source files
------------

// File: rtl/phv_ingress_sched.sv
// Round-robin PHV scheduler feeding match-action stage 0, with in-flight
// tracking and a drain/grant handshake that quiesces the pipeline for reconfiguration.
module phv_ingress_sched #(
  parameter int PHV_LEN      = 1024,
  parameter int N_PORTS      = 4,
  parameter int CNT_W        = 8,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS*PHV_LEN-1:0] s_phv_in,
  input  logic [N_PORTS-1:0]         s_phv_valid,
  output logic [N_PORTS-1:0]         s_ready_out,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic                       phv_out_valid,
  input  logic                       stage_ready_in,
  input  logic                       phv_done_valid,
  input  logic                       cfg_req,
  output logic                       cfg_grant,
  input  logic                       cfg_done,
  output logic [CNT_W-1:0]           inflight_cnt,
  output logic                       err_underflow
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CFG   = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W:0]     idx_sum;
  logic               found;
  logic               can_load;
  logic               accept;
  logic               issue;
  logic [CNT_W:0]     load_level;
  logic [PHV_LEN-1:0] phv_data [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
      assign phv_data[gi] = s_phv_in[gi*PHV_LEN +: PHV_LEN];
    end
  endgenerate

  // Scan from the highest offset down so the port closest to ptr wins last.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx_sum = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx_sum >= (PTR_W+1)'(N_PORTS))
        idx_sum = idx_sum - (PTR_W+1)'(N_PORTS);
      if (s_phv_valid[idx_sum[PTR_W-1:0]]) begin
        winner = idx_sum[PTR_W-1:0];
        found  = 1'b1;
      end
    end
  end

  // A PHV sitting in the output register already counts against the ceiling.
  assign load_level = {1'b0, inflight_cnt} + (CNT_W+1)'(phv_out_valid);
  assign can_load   = !rst && (state == RUN) && (!phv_out_valid || stage_ready_in) &&
                      (load_level < (CNT_W+1)'(MAX_INFLIGHT));
  assign accept      = can_load && found;
  assign issue       = phv_out_valid && stage_ready_in;
  assign s_ready_out = accept ? (N_PORTS'(1) << winner) : '0;
  assign ptr_next    = (winner == PTR_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (cfg_req) state_next = DRAIN;
      DRAIN:   if (!phv_out_valid && (inflight_cnt == '0)) state_next = CFG;
      CFG:     if (cfg_done) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      ptr           <= '0;
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      inflight_cnt  <= '0;
      err_underflow <= 1'b0;
      cfg_grant     <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_grant <= (state == CFG) && !cfg_done;

      if (accept) begin
        phv_out       <= phv_data[winner];
        phv_out_valid <= 1'b1;
        ptr           <= ptr_next;
      end else if (issue) begin
        phv_out_valid <= 1'b0;
      end

      case ({issue, phv_done_valid})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   if (inflight_cnt != '0) inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase

      if (phv_done_valid && (inflight_cnt == '0))
        err_underflow <= 1'b1;
    end
  end

endmodule
